// File: rtl/alu_stim_pkg.sv
// Shared types and helpers for the ALU stimulus sequencer: FSM states, mode codes,
// maximal-length Galois LFSR toggle masks and a population count.
package alu_stim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_RUN,
    ST_POST,
    ST_DONE
  } state_t;

  localparam logic MODE_EXH = 1'b0;
  localparam logic MODE_RND = 1'b1;

  // Right-shift Galois toggle masks; tap k of the polynomial maps to bit k-1.
  function automatic logic [31:0] lfsr_taps(input int n);
    case (n)
      4:       lfsr_taps = 32'h0000_000C;
      5:       lfsr_taps = 32'h0000_0014;
      6:       lfsr_taps = 32'h0000_0030;
      7:       lfsr_taps = 32'h0000_0060;
      8:       lfsr_taps = 32'h0000_00B8;
      9:       lfsr_taps = 32'h0000_0110;
      10:      lfsr_taps = 32'h0000_0240;
      11:      lfsr_taps = 32'h0000_0500;
      12:      lfsr_taps = 32'h0000_0E08;
      13:      lfsr_taps = 32'h0000_1C80;
      14:      lfsr_taps = 32'h0000_3802;
      15:      lfsr_taps = 32'h0000_6000;
      16:      lfsr_taps = 32'h0000_B400;
      default: lfsr_taps = 32'h0000_0000;
    endcase
  endfunction

  function automatic int unsigned popcount(input logic [63:0] v);
    popcount = 0;
    for (int i = 0; i < 64; i++) begin
      popcount += 32'(v[i]);
    end
  endfunction

endpackage

// File: rtl/alu_stim_lfsr.sv
// N-bit Galois LFSR; load takes priority over step, and an all-zero seed loads as 1
// so the register can never lock up.
module alu_stim_lfsr
  import alu_stim_pkg::*;
#(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic [N-1:0] seed,
  output logic [N-1:0] state
);

  localparam logic [N-1:0] TAPS = N'(lfsr_taps(N));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= '0;
    end else if (load) begin
      state <= (seed == '0) ? N'(1) : seed;
    end else if (step) begin
      state <= (state >> 1) ^ (state[0] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/alu_stim_sequencer.sv
// Start/done stimulus engine: exhaustive or LFSR sweep of {A,B,op}, each vector held H cycles,
// with a saturating Hamming-toggle accumulator on the DUT response as a power proxy.
module alu_stim_sequencer
  import alu_stim_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int OP_W        = 2,
  parameter int RESP_W      = 7,
  parameter int HOLD_W      = 4,
  parameter int PRE_CYCLES  = 2,
  parameter int POST_CYCLES = 10,
  parameter int CNT_W       = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      mode,
  input  logic [2*WIDTH+OP_W-1:0]   seed,
  input  logic [HOLD_W-1:0]         hold_cycles,
  input  logic [RESP_W-1:0]         resp,
  output logic [WIDTH-1:0]          stim_a,
  output logic [WIDTH-1:0]          stim_b,
  output logic [OP_W-1:0]           stim_op,
  output logic                      stim_valid,
  output logic [2*WIDTH+OP_W-1:0]   vec_index,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_W-1:0]          toggle_count
);

  localparam int N      = 2 * WIDTH + OP_W;
  localparam int PH_MAX = (PRE_CYCLES > POST_CYCLES) ? PRE_CYCLES : POST_CYCLES;
  localparam int PH_W   = (PH_MAX < 2) ? 1 : $clog2(PH_MAX);
  localparam logic [N-1:0] LAST_EXH = '1;
  localparam logic [N-1:0] LAST_RND = LAST_EXH - N'(1);

  state_t            state, state_nxt;
  logic              mode_q;
  logic [HOLD_W-1:0] hold_q, hold_cnt;
  logic [PH_W-1:0]   phase_cnt;
  logic [N-1:0]      vec_q, lfsr_state;
  logic [RESP_W-1:0] resp_q;
  logic              resp_primed;
  logic [CNT_W:0]    tog_sum;
  logic              go, vec_done, last_vec, pre_done, post_done, lfsr_load, lfsr_step;

  assign go        = start && !abort;
  assign vec_done  = (hold_cnt == hold_q - HOLD_W'(1));
  assign last_vec  = (vec_q == ((mode_q == MODE_RND) ? LAST_RND : LAST_EXH));
  assign pre_done  = (phase_cnt == PH_W'(PRE_CYCLES - 1));
  assign post_done = (phase_cnt == PH_W'(POST_CYCLES - 1));
  assign lfsr_load = (state == ST_IDLE) && go;
  assign lfsr_step = (state == ST_RUN) && !abort && vec_done && !last_vec && (mode_q == MODE_RND);

  // vec_q is the ordinal in both modes; in random mode the LFSR supplies the vector word.
  assign vec_index = vec_q;
  assign {stim_a, stim_b, stim_op} = (mode_q == MODE_RND) ? lfsr_state : vec_q;

  assign tog_sum = {1'b0, toggle_count} + (CNT_W+1)'(popcount(64'(resp ^ resp_q)));

  alu_stim_lfsr #(.N(N)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .seed  (seed),
    .state (lfsr_state)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    done       = 1'b0;
    stim_valid = 1'b0;
    unique case (state)
      ST_IDLE: if (go) state_nxt = (PRE_CYCLES == 0) ? ST_RUN : ST_PRE;
      ST_PRE: begin
        busy = 1'b1;
        if (pre_done) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy       = 1'b1;
        stim_valid = 1'b1;
        if (vec_done && last_vec) state_nxt = (POST_CYCLES == 0) ? ST_DONE : ST_POST;
      end
      ST_POST: begin
        busy = 1'b1;
        if (post_done) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  // Datapath freezes on abort so stimulus and toggle_count keep their last values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q       <= MODE_EXH;
      hold_q       <= '0;
      hold_cnt     <= '0;
      phase_cnt    <= '0;
      vec_q        <= '0;
      resp_q       <= '0;
      resp_primed  <= 1'b0;
      toggle_count <= '0;
    end else if (!abort) begin
      unique case (state)
        ST_IDLE: if (start) begin
          mode_q       <= mode;
          hold_q       <= (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
          hold_cnt     <= '0;
          phase_cnt    <= '0;
          vec_q        <= '0;
          resp_primed  <= 1'b0;
          toggle_count <= '0;
        end
        ST_PRE: phase_cnt <= pre_done ? '0 : phase_cnt + PH_W'(1);
        ST_RUN: begin
          if (vec_done) begin
            hold_cnt <= '0;
            if (!last_vec) vec_q <= vec_q + N'(1);
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        ST_POST: phase_cnt <= phase_cnt + PH_W'(1);
        default: ;
      endcase
      if (state == ST_RUN || state == ST_POST) begin
        resp_q      <= resp;
        resp_primed <= 1'b1;
        if (resp_primed) toggle_count <= tog_sum[CNT_W] ? '1 : tog_sum[CNT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_alu_stim_sequencer.sv
// Bench for alu_stim_sequencer: a default-size instance for the full exhaustive sweep and a
// narrow instance (N=6, 8-bit counter) for random, toggle, hold, abort and reset scenarios.
module tb_alu_stim_sequencer;

  localparam int PRE  = 2;
  localparam int POST = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default instance: WIDTH=4, OP_W=2 (N=10), CNT_W=32
  logic       a_start, a_abort, a_mode;
  logic [9:0] a_seed;
  logic [3:0] a_hold;
  logic [6:0] a_resp;
  logic [3:0] a_sa, a_sb;
  logic [1:0] a_op;
  logic       a_valid, a_busy, a_done;
  logic [9:0] a_idx;
  logic [31:0] a_tog;

  // Narrow instance: WIDTH=2, OP_W=2 (N=6), CNT_W=8
  logic       b_start, b_abort, b_mode;
  logic [5:0] b_seed;
  logic [3:0] b_hold;
  logic [6:0] b_resp, resp_drv;
  logic       follow;
  logic [1:0] b_sa, b_sb, b_op;
  logic       b_valid, b_busy, b_done;
  logic [5:0] b_idx;
  logic [7:0] b_tog;

  assign b_resp = follow ? {5'b0, b_sa} : resp_drv;

  int total = 0;
  int bad   = 0;

  logic [5:0] vq[$];
  logic [5:0] iq[$];
  logic [6:0] rq[$];
  int busy_n, done_at, first_valid;

  alu_stim_sequencer dut_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort), .mode(a_mode), .seed(a_seed),
    .hold_cycles(a_hold), .resp(a_resp), .stim_a(a_sa), .stim_b(a_sb), .stim_op(a_op),
    .stim_valid(a_valid), .vec_index(a_idx), .busy(a_busy), .done(a_done), .toggle_count(a_tog)
  );

  alu_stim_sequencer #(.WIDTH(2), .OP_W(2), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .mode(b_mode), .seed(b_seed),
    .hold_cycles(b_hold), .resp(b_resp), .stim_a(b_sa), .stim_b(b_sb), .stim_op(b_op),
    .stim_valid(b_valid), .vec_index(b_idx), .busy(b_busy), .done(b_done), .toggle_count(b_tog)
  );

  // Reference toggle count: cycles numbered from 1 after the start edge; RUN+POST span is
  // PRE+1 .. PRE+H*count+POST, the first of which only primes the previous-response value.
  function automatic int exp_toggles(input int h, input int count, input int cmax);
    int first, last, acc;
    logic [6:0] q;
    first = PRE + 1;
    last  = PRE + h * count + POST;
    acc   = 0;
    q     = '0;
    for (int c = first; c <= last && c <= rq.size(); c++) begin
      if (c == first) q = rq[c-1];
      else begin
        acc += $countones(rq[c-1] ^ q);
        q = rq[c-1];
      end
    end
    return (acc > cmax) ? cmax : acc;
  endfunction

  // Starts one run on the narrow instance and records every cycle until done or budget.
  task automatic run_b(input logic m, input logic [5:0] sd, input logic [3:0] h,
                       input logic [6:0] rmask, input bit poke, input int budget);
    vq.delete(); iq.delete(); rq.delete();
    busy_n = 0; done_at = -1; first_valid = -1;
    @(negedge clk);
    b_start = 1'b1; b_mode = m; b_seed = sd; b_hold = h;
    @(negedge clk);
    b_start = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      if (b_busy) busy_n++;
      if (b_valid) begin
        if (first_valid < 0) first_valid = c;
        vq.push_back({b_sa, b_sb, b_op});
        iq.push_back(b_idx);
      end
      if (b_done) begin
        done_at = c;
        break;
      end
      resp_drv = 7'($urandom) & rmask;
      rq.push_back(resp_drv);
      if (c == 5) b_hold = 4'($urandom);
      b_start = poke && (c % 7 == 0);
      @(negedge clk);
    end
    b_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    total++; if (a_busy !== 1'b0 || a_done !== 1'b0 || a_valid !== 1'b0) begin bad++; $display("FAIL rst_a_ctrl: got busy=%b done=%b valid=%b want 0", a_busy, a_done, a_valid); end
    total++; if ({a_sa, a_sb, a_op} !== 10'd0 || a_idx !== 10'd0) begin bad++; $display("FAIL rst_a_stim: got %h idx %h want 0", {a_sa, a_sb, a_op}, a_idx); end
    total++; if (a_tog !== 32'd0) begin bad++; $display("FAIL rst_a_tog: got %0d want 0", a_tog); end
    total++; if (b_busy !== 1'b0 || b_done !== 1'b0 || b_valid !== 1'b0) begin bad++; $display("FAIL rst_b_ctrl: got busy=%b done=%b valid=%b want 0", b_busy, b_done, b_valid); end
    total++; if ({b_sa, b_sb, b_op} !== 6'd0 || b_idx !== 6'd0 || b_tog !== 8'd0) begin bad++; $display("FAIL rst_b_out: got stim %h idx %h tog %0d want 0", {b_sa, b_sb, b_op}, b_idx, b_tog); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_exhaustive();
    int nvalid, seq_err;
    logic [9:0] v, v0, v1, v4, lastv;
    nvalid = 0; seq_err = 0; busy_n = 0; done_at = -1; first_valid = -1;
    v0 = 'x; v1 = 'x; v4 = 'x; lastv = 'x;
    @(negedge clk);
    a_start = 1'b1; a_mode = 1'b0; a_hold = 4'd3;
    @(negedge clk);
    a_start = 1'b0;
    for (int c = 1; c <= 4000; c++) begin
      if (a_busy) busy_n++;
      if (a_valid) begin
        v = {a_sa, a_sb, a_op};
        if (first_valid < 0) first_valid = c;
        if (v !== 10'(nvalid / 3) || a_idx !== 10'(nvalid / 3)) seq_err++;
        if (nvalid / 3 == 0) v0 = v;
        if (nvalid / 3 == 1) v1 = v;
        if (nvalid / 3 == 4) v4 = v;
        lastv = v;
        nvalid++;
      end
      if (a_done) begin
        done_at = c;
        break;
      end
      @(negedge clk);
    end
    total++; if (first_valid != PRE + 1) begin bad++; $display("FAIL exh_first_cycle: got %0d want %0d", first_valid, PRE + 1); end
    total++; if (v0 !== 10'd0) begin bad++; $display("FAIL exh_vec0: got %h want 0", v0); end
    total++; if (v1 !== {4'd0, 4'd0, 2'd1}) begin bad++; $display("FAIL exh_vec1: got %h want %h", v1, {4'd0, 4'd0, 2'd1}); end
    total++; if (v4 !== {4'd0, 4'd1, 2'd0}) begin bad++; $display("FAIL exh_vec4: got %h want %h", v4, {4'd0, 4'd1, 2'd0}); end
    total++; if (lastv !== {4'hf, 4'hf, 2'd3}) begin bad++; $display("FAIL exh_last: got %h want %h", lastv, {4'hf, 4'hf, 2'd3}); end
    total++; if (seq_err != 0 || nvalid != 3072) begin bad++; $display("FAIL exh_sequence: got %0d errors over %0d cycles want 0 over 3072", seq_err, nvalid); end
    total++; if (busy_n != PRE + 3072 + POST) begin bad++; $display("FAIL exh_busy_cycles: got %0d want %0d", busy_n, PRE + 3072 + POST); end
    total++; if (done_at != PRE + 3072 + POST + 1) begin bad++; $display("FAIL exh_done_cycle: got %0d want %0d", done_at, PRE + 3072 + POST + 1); end
    @(negedge clk);
    total++; if (a_done !== 1'b0 || a_valid !== 1'b0 || {a_sa, a_sb, a_op} !== {4'hf, 4'hf, 2'd3}) begin bad++; $display("FAIL exh_after_done: got done=%b valid=%b stim=%h want 0 0 3ff", a_done, a_valid, {a_sa, a_sb, a_op}); end
    total++; if (a_tog !== 32'd0) begin bad++; $display("FAIL exh_quiet_tog: got %0d want 0", a_tog); end
  endtask

  task automatic test_random(input logic [5:0] sd);
    int h, errs;
    bit [63:0] seen;
    logic [5:0] v, exp0;
    h = $urandom_range(1, 3);
    follow = 1'b0;
    run_b(1'b1, sd, 4'(h), 7'h01, 1'b0, 400);
    total++; if (done_at < 0) begin bad++; $display("FAIL rnd_timeout: got no done want done (seed %0d)", sd); end
    total++; if (vq.size() != 63 * h) begin bad++; $display("FAIL rnd_valid_cycles: got %0d want %0d", vq.size(), 63 * h); end
    errs = 0; seen = '0;
    if (vq.size() == 63 * h) begin
      for (int k = 0; k < 63; k++) begin
        v = vq[k*h];
        if (v == 6'd0 || seen[v]) errs++;
        seen[v] = 1'b1;
        for (int j = 0; j < h; j++) begin
          if (vq[k*h+j] !== v || iq[k*h+j] !== 6'(k)) errs++;
        end
      end
    end
    total++; if (errs != 0 || $countones(seen) != 63) begin bad++; $display("FAIL rnd_distinct: got %0d errors %0d distinct want 0 errors 63 distinct", errs, $countones(seen)); end
    exp0 = (sd == 6'd0) ? 6'd1 : sd;
    total++; if (vq.size() == 0 || vq[0] !== exp0) begin bad++; $display("FAIL rnd_first_vec: got %h want %h", (vq.size() == 0) ? 6'd0 : vq[0], exp0); end
    total++; if (busy_n != PRE + 63 * h + POST) begin bad++; $display("FAIL rnd_busy_cycles: got %0d want %0d", busy_n, PRE + 63 * h + POST); end
    total++; if (b_tog !== 8'(exp_toggles(h, 63, 255))) begin bad++; $display("FAIL rnd_toggles: got %0d want %0d", b_tog, exp_toggles(h, 63, 255)); end
  endtask

  task automatic test_toggle_follow();
    follow = 1'b1;
    run_b(1'b0, 6'd0, 4'd1, 7'h00, 1'b0, 200);
    follow = 1'b0;
    total++; if (done_at < 0 || b_tog !== 8'd4) begin bad++; $display("FAIL tog_follow: got %0d (done_at %0d) want 4", b_tog, done_at); end
  endtask

  task automatic test_saturate();
    run_b(1'b0, 6'd0, 4'd4, 7'h7f, 1'b0, 500);
    total++; if (done_at < 0 || b_tog !== 8'(exp_toggles(4, 64, 255))) begin bad++; $display("FAIL tog_saturate: got %0d want %0d", b_tog, exp_toggles(4, 64, 255)); end
  endtask

  task automatic test_hold_zero();
    int errs;
    errs = 0;
    run_b(1'b0, 6'($urandom), 4'd0, 7'h03, 1'b0, 200);
    total++; if (vq.size() != 64) begin bad++; $display("FAIL hold0_count: got %0d want 64", vq.size()); end
    for (int k = 0; k < vq.size(); k++) if (vq[k] !== 6'(k)) errs++;
    total++; if (errs != 0) begin bad++; $display("FAIL hold0_seq: got %0d mismatched vectors want 0", errs); end
    total++; if (busy_n != PRE + 64 + POST) begin bad++; $display("FAIL hold0_busy: got %0d want %0d", busy_n, PRE + 64 + POST); end
    total++; if (b_tog !== 8'(exp_toggles(1, 64, 255))) begin bad++; $display("FAIL hold0_toggles: got %0d want %0d", b_tog, exp_toggles(1, 64, 255)); end
  endtask

  task automatic test_abort();
    int nrun, dseen, bseen;
    nrun = 0; dseen = 0; bseen = 0;
    resp_drv = '0;
    @(negedge clk);
    b_start = 1'b1; b_mode = 1'b0; b_hold = 4'd2;
    @(negedge clk);
    b_start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (b_valid) nrun++;
      if (nrun == 10) break;
      @(negedge clk);
    end
    total++; if (nrun != 10) begin bad++; $display("FAIL abort_reach_run: got %0d run cycles want 10", nrun); end
    b_abort = 1'b1;
    @(negedge clk);
    b_abort = 1'b0;
    total++; if (b_busy !== 1'b0 || b_valid !== 1'b0 || b_done !== 1'b0) begin bad++; $display("FAIL abort_next: got busy=%b valid=%b done=%b want 0 0 0", b_busy, b_valid, b_done); end
    repeat (30) begin
      @(negedge clk);
      if (b_done) dseen++;
      if (b_busy) bseen++;
    end
    total++; if (dseen != 0 || bseen != 0) begin bad++; $display("FAIL abort_no_done: got %0d done %0d busy cycles want 0 0", dseen, bseen); end
    run_b(1'b0, 6'd0, 4'd2, 7'h01, 1'b0, 300);
    total++; if (vq.size() == 0 || iq[0] !== 6'd0 || vq[0] !== 6'd0 || first_valid != PRE + 1) begin bad++; $display("FAIL abort_restart: got first_valid %0d size %0d want restart at index 0 cycle %0d", first_valid, vq.size(), PRE + 1); end
    total++; if (done_at != PRE + 128 + POST + 1) begin bad++; $display("FAIL abort_restart_done: got %0d want %0d", done_at, PRE + 128 + POST + 1); end
    @(negedge clk);
    b_start = 1'b1; b_abort = 1'b1;
    @(negedge clk);
    b_start = 1'b0; b_abort = 1'b0;
    bseen = 0;
    repeat (4) begin
      if (b_busy) bseen++;
      @(negedge clk);
    end
    total++; if (bseen != 0) begin bad++; $display("FAIL abort_beats_start: got %0d busy cycles want 0", bseen); end
  endtask

  task automatic test_start_busy();
    int errs;
    errs = 0;
    run_b(1'b0, 6'd0, 4'd1, 7'h01, 1'b1, 200);
    for (int k = 0; k < vq.size(); k++) if (vq[k] !== 6'(k)) errs++;
    total++; if (vq.size() != 64 || errs != 0) begin bad++; $display("FAIL busy_start_seq: got %0d vectors %0d errors want 64 0", vq.size(), errs); end
    total++; if (busy_n != PRE + 64 + POST || done_at != PRE + 64 + POST + 1) begin bad++; $display("FAIL busy_start_timing: got busy %0d done %0d want %0d %0d", busy_n, done_at, PRE + 64 + POST, PRE + 64 + POST + 1); end
    @(negedge clk);
    total++; if (b_busy !== 1'b0 || b_done !== 1'b0) begin bad++; $display("FAIL busy_start_idle: got busy=%b done=%b want 0 0", b_busy, b_done); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    b_start = 1'b1; b_mode = 1'b1; b_seed = 6'($urandom_range(1, 63)); b_hold = 4'd2;
    @(negedge clk);
    b_start = 1'b0;
    repeat (20) begin
      resp_drv = 7'($urandom);
      @(negedge clk);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (b_busy !== 1'b0 || b_valid !== 1'b0 || b_done !== 1'b0) begin bad++; $display("FAIL rst_mid_ctrl: got busy=%b valid=%b done=%b want 0", b_busy, b_valid, b_done); end
    total++; if ({b_sa, b_sb, b_op} !== 6'd0 || b_idx !== 6'd0 || b_tog !== 8'd0) begin bad++; $display("FAIL rst_mid_data: got stim %h idx %h tog %0d want 0", {b_sa, b_sb, b_op}, b_idx, b_tog); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (b_busy !== 1'b0) begin bad++; $display("FAIL rst_mid_idle: got busy=%b want 0", b_busy); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    a_start = 0; a_abort = 0; a_mode = 0; a_seed = '0; a_hold = '0; a_resp = '0;
    b_start = 0; b_abort = 0; b_mode = 0; b_seed = '0; b_hold = '0; resp_drv = '0; follow = 0;
    test_reset();
    test_exhaustive();
    test_random(6'd0);
    test_random(6'($urandom_range(1, 63)));
    test_toggle_follow();
    test_saturate();
    test_hold_zero();
    test_abort();
    test_start_busy();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
